apb_wait_slave: RTL

APB completer (slave) that answers transfers started by the APB master in the processor-side APB block. It holds a small register file plus a programmable wait-state register, so one instance can sit on either APB port. Each instance is selected by its `id` strap and inserts a configurable number of wait states before `ready`. Out-of-range addresses get an error response.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_regfile.sv | 30 +++
 rtl/apb_wait_slave.sv | 134 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB wait-state completer.
// Holds the FSM encoding, the wait_cfg address and the data-address decode helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } apb_slv_state_t;

   localparam logic [7:0] WAIT_CFG_ADDR = 8'hFF;
   localparam int unsigned WAIT_W = 4;

   function automatic logic is_data_addr(input logic [7:0] a, input logic [7:0] depth);
      return a < depth;
   endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 8 register file: one synchronous write port, one combinational read port,
// synchronous clear on reset.
module apb_regfile #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with a small register file and a programmable wait-state count.
// Responds only when sel matches the id strap; ready/error/rdata are registered.
module apb_wait_slave
   import apb_pkg::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned DEFAULT_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] id,
   input  logic [1:0] sel,
   input  logic       enable,
   input  logic       write,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       ready,
   output logic       error
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_RST = WAIT_W'(DEFAULT_WAIT);

   apb_slv_state_t state, next_state;

   logic [7:0]        addr_q;
   logic              write_q;
   logic [7:0]        wdata_q;
   logic              err_q;
   logic [WAIT_W-1:0] wcnt;
   logic [WAIT_W-1:0] wait_cfg;

   logic       selected, setup, access, addr_ok;
   logic       load, dec, commit;
   logic [7:0] resp_addr;
   logic       resp_write, resp_err;
   logic [7:0] rf_rdata, rd_val;
   logic       rf_we;
   logic       ready_q, error_q;
   logic [7:0] rdata_q;

   assign selected = (sel == id);
   assign setup    = selected && !enable;
   assign access   = selected && enable;
   assign addr_ok  = is_data_addr(addr, DEPTH_B) || (addr == WAIT_CFG_ADDR);

   always_comb begin
      next_state = state;
      load       = 1'b0;
      dec        = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (setup) begin
               load = 1'b1;
               if (addr_ok && (wait_cfg != '0)) next_state = WAIT;
               else                             next_state = RESP;
            end
         end
         WAIT: begin
            if (!access)                        next_state = IDLE;
            else if (wcnt <= WAIT_W'(1))        next_state = RESP;
            else                                dec = 1'b1;
         end
         RESP: begin
            next_state = IDLE;
            commit     = access && write_q && !err_q;
         end
         default: next_state = IDLE;
      endcase
   end

   // The response registers are loaded in the cycle that enters RESP, so they must see
   // the setup-phase values directly when RESP follows setup with no wait states.
   always_comb begin
      resp_addr  = load ? addr  : addr_q;
      resp_write = load ? write : write_q;
      resp_err   = load ? !addr_ok : err_q;
      rd_val     = (resp_addr == WAIT_CFG_ADDR) ? 8'(wait_cfg) : rf_rdata;
   end

   assign rf_we = commit && is_data_addr(addr_q, DEPTH_B);

   apb_regfile #(
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (rf_we),
      .waddr (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .raddr (resp_addr[AW-1:0]),
      .rdata (rf_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         wcnt     <= '0;
         wait_cfg <= WAIT_RST;
         ready_q  <= 1'b0;
         error_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state <= next_state;
         if (load) begin
            addr_q  <= addr;
            write_q <= write;
            wdata_q <= wdata;
            err_q   <= !addr_ok;
            wcnt    <= wait_cfg;
         end else if (dec) begin
            wcnt <= wcnt - WAIT_W'(1);
         end
         if (commit && (addr_q == WAIT_CFG_ADDR)) begin
            wait_cfg <= wdata_q[WAIT_W-1:0];
         end
         ready_q <= (next_state == RESP);
         error_q <= (next_state == RESP) && resp_err;
         rdata_q <= ((next_state == RESP) && !resp_write && !resp_err) ? rd_val : '0;
      end
   end

   assign ready = ready_q;
   assign error = error_q;
   assign rdata = rdata_q;

endmodule
